// File: rtl/dac_sched_pkg.sv
// Shared types and widths for the DAC scheduler slice.
package dac_sched_pkg;

    localparam int unsigned DAC_DW = 12;
    localparam int unsigned DAC_CW = 2;

    typedef logic [DAC_CW-1:0] chan_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/dac_rr_arb.sv
// Combinational round-robin pick: first pending channel at or after ptr.
module dac_rr_arb
    import dac_sched_pkg::*;
#(
    parameter int unsigned NCH = 4
) (
    input  logic [NCH-1:0] pend,
    input  chan_t          ptr,
    output chan_t          winner,
    output logic           valid
);

    // Walk offsets from farthest to nearest so the nearest pending channel wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int unsigned o = NCH; o > 0; o--) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (pend[c] && (c == ((32'(ptr) + o - 1) % NCH))) begin
                    winner = DAC_CW'(c);
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dac_scheduler.sv
// Round-robin scheduler sharing one serial DAC shifter among up to four producers.
// Optional acknowledge watchdog: define DAC_SCHED_TIMEOUT_EN.
module dac_scheduler
    import dac_sched_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  dacclk,
    input  logic                  dacrstn,
    input  logic [NCH-1:0]        wrstb,
    input  logic [NCH*DAC_DW-1:0] wrdata,
    output logic [NCH-1:0]        pend,
    output logic [NCH-1:0]        done,
    output logic                  busy,
    output logic                  err,
    output logic                  dacdav,
    input  logic                  davdac,
    output logic [DAC_CW-1:0]     daccmd,
    output logic [DAC_DW-1:0]     dacdata
);

    if ((NCH == 0) || (NCH > 4) || (TIMEOUT == 0)) begin : g_bad_cfg
        $error("dac_scheduler: NCH must be 1..4 and TIMEOUT at least 1");
    end

    state_t            state;
    state_t            state_n;
    chan_t             ptr;
    chan_t             ptr_adv;
    chan_t             win;
    logic              win_valid;
    logic              grant;
    logic              ack_evt;
    logic              to_evt;
    logic              timeout_hit;
    logic [DAC_DW-1:0] hold [NCH];
    logic [DAC_DW-1:0] win_data;

    dac_rr_arb #(
        .NCH    (NCH)
    ) u_arb (
        .pend   (pend),
        .ptr    (ptr),
        .winner (win),
        .valid  (win_valid)
    );

    // Holding register of the granted channel.
    always_comb begin
        win_data = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (32'(win) == c) begin
                win_data = hold[c];
            end
        end
    end

    // Search restarts one past the granted channel.
    always_comb begin
        ptr_adv = win + chan_t'(1);
        if ((32'(win) + 1) >= NCH) begin
            ptr_adv = '0;
        end
    end

`ifdef DAC_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt;

    // Cycles spent waiting for the acknowledge in the current transfer.
    always_ff @(posedge dacclk) begin
        if (!dacrstn || (state != SEND)) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    assign timeout_hit = (state == SEND) && (tcnt == TW'(TIMEOUT - 1));

    // Sticky watchdog flag, cleared only by reset.
    always_ff @(posedge dacclk) begin
        if (!dacrstn) begin
            err <= 1'b0;
        end else if (to_evt) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // State register.
    always_ff @(posedge dacclk) begin
        if (!dacrstn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and transfer events.
    always_comb begin
        state_n = state;
        grant   = 1'b0;
        ack_evt = 1'b0;
        to_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_n = SEND;
                    grant   = 1'b1;
                end
            end
            SEND: begin
                if (davdac) begin
                    state_n = RELEASE;
                    ack_evt = 1'b1;
                end else if (timeout_hit) begin
                    state_n = RELEASE;
                    to_evt  = 1'b1;
                end
            end
            RELEASE: begin
                if (!davdac) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Holding registers, pend bits, pointer and registered handshake outputs.
    always_ff @(posedge dacclk) begin
        if (!dacrstn) begin
            pend    <= '0;
            done    <= '0;
            busy    <= 1'b0;
            dacdav  <= 1'b0;
            daccmd  <= '0;
            dacdata <= '0;
            ptr     <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                hold[c] <= '0;
            end
        end else begin
            busy <= (state_n != IDLE);
            for (int unsigned c = 0; c < NCH; c++) begin
                // A write on the grant edge re-arms the channel with new data.
                if (wrstb[c]) begin
                    hold[c] <= wrdata[c*DAC_DW +: DAC_DW];
                    pend[c] <= 1'b1;
                end else if (grant && (32'(win) == c)) begin
                    pend[c] <= 1'b0;
                end
                done[c] <= ack_evt && (32'(daccmd) == c);
            end
            if (grant) begin
                dacdav  <= 1'b1;
                daccmd  <= win;
                dacdata <= win_data;
                ptr     <= ptr_adv;
            end else if (ack_evt || to_evt) begin
                dacdav  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_scheduler.sv
// Self-checking bench for dac_scheduler against a transaction-level reference model.
module tb_dac_scheduler;
    import dac_sched_pkg::*;

    localparam int unsigned NCH     = 4;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned WW      = NCH * 12;

    logic            dacclk = 1'b0;
    logic            dacrstn;
    logic [NCH-1:0]  wrstb;
    logic [WW-1:0]   wrdata;
    logic [NCH-1:0]  pend;
    logic [NCH-1:0]  done;
    logic            busy;
    logic            err;
    logic            dacdav;
    logic            davdac;
    logic [1:0]      daccmd;
    logic [11:0]     dacdata;

    dac_scheduler #(
        .NCH     (NCH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .dacclk  (dacclk),
        .dacrstn (dacrstn),
        .wrstb   (wrstb),
        .wrdata  (wrdata),
        .pend    (pend),
        .done    (done),
        .busy    (busy),
        .err     (err),
        .dacdav  (dacdav),
        .davdac  (davdac),
        .daccmd  (daccmd),
        .dacdata (dacdata)
    );

    always #5 dacclk = ~dacclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending samples, pointer, and transfer phase.
    int unsigned m_phase;   // 0 idle, 1 waiting for ack, 2 waiting for ack release
    logic [11:0] m_val [NCH];
    logic [NCH-1:0] m_pend;
    int unsigned m_ptr;
    logic        m_dav;
    logic [1:0]  m_cmd;
    logic [11:0] m_data;
    logic [NCH-1:0] m_done;
    logic        m_err;
    int unsigned m_wait;

    // Bench-side serializer and observation state.
    logic rst_drv = 1'b0;
    logic ack_drv = 1'b0;
    int   ack_mode = 0;     // 0 never ack, 1 ack immediately, 2 random delays
    logic prev_dav = 1'b0;
    logic seen_high = 1'b0;
    int   low_run = 0;
    int   obs_cmd [$];
    logic [11:0] obs_data [$];
    int   done_cnt [NCH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] mkwd(input int unsigned ch, input logic [11:0] v);
        logic [WW-1:0] r;
        r = '0;
        r[ch*12 +: 12] = v;
        return r;
    endfunction

    function automatic int unsigned m_pick();
        for (int unsigned o = 0; o < NCH; o++) begin
            if (m_pend[(m_ptr + o) % NCH]) return (m_ptr + o) % NCH;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pend = '0; m_ptr = 0; m_dav = 1'b0; m_cmd = '0;
        m_data = '0; m_done = '0; m_err = 1'b0; m_wait = 0;
        for (int c = 0; c < NCH; c++) m_val[c] = '0;
    endtask

    // One clock edge of the transaction rules.
    task automatic model_edge(input logic rn, input logic [NCH-1:0] wr,
                              input logic [WW-1:0] wd, input logic ack);
        int unsigned k;
        m_done = '0;
        if (!rn) begin
            model_reset();
        end else begin
            case (m_phase)
                0: if (m_pend != '0) begin
                    k = m_pick();
                    m_cmd = 2'(k); m_data = m_val[k]; m_pend[k] = 1'b0;
                    m_ptr = (k + 1) % NCH; m_dav = 1'b1; m_phase = 1; m_wait = 0;
                end
                1: if (ack) begin
                    m_dav = 1'b0; m_done[m_cmd] = 1'b1; m_phase = 2;
                end else begin
                    m_wait++;
`ifdef DAC_SCHED_TIMEOUT_EN
                    if (m_wait == TIMEOUT) begin
                        m_dav = 1'b0; m_err = 1'b1; m_phase = 2;
                    end
`endif
                end
                default: if (!ack) m_phase = 0;
            endcase
            for (int c = 0; c < NCH; c++) begin
                if (wr[c]) begin
                    m_val[c] = wd[c*12 +: 12];
                    m_pend[c] = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, compare every output.
    task automatic tick(input logic [NCH-1:0] wr, input logic [WW-1:0] wd);
        wrstb = wr; wrdata = wd; davdac = ack_drv; dacrstn = rst_drv;
        @(posedge dacclk);
        #1;
        model_edge(rst_drv, wr, wd, ack_drv);
        check("dacdav", 32'(dacdav), 32'(m_dav));
        check("daccmd", 32'(daccmd), 32'(m_cmd));
        check("dacdata", 32'(dacdata), 32'(m_data));
        check("pend", 32'(pend), 32'(m_pend));
        check("done", 32'(done), 32'(m_done));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("err", 32'(err), 32'(m_err));
        if (dacdav && !prev_dav) begin
            obs_cmd.push_back(int'(daccmd));
            obs_data.push_back(dacdata);
            if (seen_high) check("gap", 32'(low_run >= 2), 32'd1);
            seen_high = 1'b1;
        end
        if (dacdav) low_run = 0; else low_run++;
        prev_dav = dacdav;
        if (!rst_drv) seen_high = 1'b0;
        for (int c = 0; c < NCH; c++) if (done[c]) done_cnt[c]++;
        case (ack_mode)
            0: ack_drv = 1'b0;
            1: ack_drv = m_dav;
            default: begin
                if (m_dav && !ack_drv) ack_drv = ($urandom_range(0, 2) == 0);
                else if (!m_dav && ack_drv) ack_drv = ($urandom_range(0, 1) == 0);
            end
        endcase
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick('0, (WW)'({$urandom(), $urandom()}));
    endtask

    int mark;
    int cnt;
    int dsum;

    initial begin
        model_reset();
        for (int c = 0; c < NCH; c++) done_cnt[c] = 0;

        // Reset values
        rst_drv = 1'b0;
        idle_ticks(2);
        check("rst_dav", 32'(dacdav), 32'd0);
        check("rst_pend", 32'(pend), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_drv = 1'b1;

        // Single write: latency, held data, done pulse
        ack_mode = 0;
        tick(4'b0100, mkwd(2, 12'hABC));
        check("lat_pend", 32'(pend), 32'h4);
        check("lat_dav_lo", 32'(dacdav), 32'd0);
        tick('0, '0);
        check("lat_dav_hi", 32'(dacdav), 32'd1);
        check("single_cmd", 32'(daccmd), 32'd2);
        check("single_data", 32'(dacdata), 32'hABC);
        idle_ticks(3);
        ack_mode = 1; ack_drv = 1'b1;
        tick('0, '0);
        check("single_done", 32'(done), 32'h4);
        idle_ticks(4);
        check("single_done_cnt", 32'(done_cnt[2]), 32'd1);

        // Reset during SEND aborts the transfer
        ack_mode = 0;
        tick(4'b1000, mkwd(3, 12'h333));
        tick('0, '0);
        tick(4'b0001, mkwd(0, 12'h5A5));
        rst_drv = 1'b0;
        tick('0, '0);
        check("mrst_dav", 32'(dacdav), 32'd0);
        check("mrst_pend", 32'(pend), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        rst_drv = 1'b1;
        idle_ticks(3);
        check("mrst_quiet", 32'(dacdav), 32'd0);

        // Fairness: all four channels in one cycle, pointer fresh from reset
        mark = obs_cmd.size();
        for (int c = 0; c < NCH; c++) done_cnt[c] = 0;
        ack_mode = 1;
        tick(4'b1111, {12'h004, 12'h003, 12'h002, 12'h001});
        idle_ticks(30);
        check("fair_n", 32'(obs_cmd.size() - mark), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (mark + i < obs_cmd.size()) begin
                check("fair_cmd", 32'(obs_cmd[mark + i]), 32'(i));
                check("fair_data", 32'(obs_data[mark + i]), 32'(i + 1));
            end
            check("fair_done", 32'(done_cnt[i]), 32'd1);
        end

        // Coalescing: ch1 rewritten while ch0 holds the shifter
        ack_mode = 0;
        tick(4'b0001, mkwd(0, 12'h050));
        tick('0, '0);
        mark = obs_cmd.size();
        tick(4'b0010, mkwd(1, 12'h111));
        tick('0, '0);
        tick(4'b0010, mkwd(1, 12'h222));
        idle_ticks(3);
        ack_mode = 1; ack_drv = 1'b1;
        idle_ticks(20);
        cnt = 0;
        for (int i = mark; i < obs_cmd.size(); i++) begin
            if (obs_cmd[i] == 1) begin
                cnt++;
                check("coal_data", 32'(obs_data[i]), 32'h222);
            end
        end
        check("coal_count", 32'(cnt), 32'd1);

        // Rewrite during flight: in-flight data stays, second transfer follows
        ack_mode = 0;
        mark = obs_cmd.size();
        tick(4'b0001, mkwd(0, 12'h100));
        tick('0, '0);
        tick(4'b0001, mkwd(0, 12'h200));
        check("flight_hold0", 32'(dacdata), 32'h100);
        idle_ticks(3);
        check("flight_hold1", 32'(dacdata), 32'h100);
        ack_mode = 1; ack_drv = 1'b1;
        idle_ticks(20);
        check("flight_n", 32'(obs_cmd.size() - mark), 32'd2);
        if (obs_cmd.size() - mark == 2) begin
            check("flight_c0", 32'(obs_cmd[mark]), 32'd0);
            check("flight_d0", 32'(obs_data[mark]), 32'h100);
            check("flight_c1", 32'(obs_cmd[mark + 1]), 32'd0);
            check("flight_d1", 32'(obs_data[mark + 1]), 32'h200);
        end

        // Random traffic with random serializer delays
        ack_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            tick(NCH'($urandom() & $urandom() & $urandom()), (WW)'({$urandom(), $urandom()}));
        end
        ack_mode = 1; ack_drv = m_dav;
        idle_ticks(30);
        check("drain_pend", 32'(pend), 32'd0);

`ifdef DAC_SCHED_TIMEOUT_EN
        // Watchdog: ack never arrives
        rst_drv = 1'b0;
        idle_ticks(1);
        rst_drv = 1'b1;
        ack_mode = 0; ack_drv = 1'b0;
        dsum = done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3];
        tick(4'b0011, {12'h000, 12'h000, 12'h0B1, 12'h0A0});
        tick('0, '0);
        check("to_rise", 32'(dacdav), 32'd1);
        cnt = 1;
        while (dacdav && cnt < 200) begin
            tick('0, '0);
            if (dacdav) cnt++;
        end
        check("to_len", 32'(cnt), 32'(TIMEOUT));
        check("to_err", 32'(err), 32'd1);
        cnt = 0;
        while (!dacdav && cnt < 10) begin
            tick('0, '0);
            cnt++;
        end
        check("to_next_dav", 32'(dacdav), 32'd1);
        check("to_next_cmd", 32'(daccmd), 32'd1);
        idle_ticks(80);
        check("to_err_sticky", 32'(err), 32'd1);
        check("to_no_done", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3]), 32'(dsum));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
